// File: rtl/alu_sequencer_pkg.sv
// Shared op codes, FSM encoding and latched-command layout for alu_sequencer.
package alu_sequencer_pkg;
    localparam int REGW = 3;

    localparam logic [1:0] ADD  = 2'b00;
    localparam logic [1:0] SUB  = 2'b01;
    localparam logic [1:0] AND  = 2'b10;
    localparam logic [1:0] MOVA = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOADA = 3'd1,
        LOADB = 3'd2,
        EXEC  = 3'd3,
        WRITE = 3'd4
    } state_e;

    typedef struct packed {
        logic            imm;
        logic [1:0]      op;
        logic [REGW-1:0] rd;
        logic [REGW-1:0] rn;
        logic [REGW-1:0] rm;
    } cmd_t;
endpackage

// File: rtl/alu_sequencer_regfile.sv
// NREG x k register file: one synchronous write port, operand and debug combinational reads.
module regfile
    import alu_sequencer_pkg::*;
#(
    parameter int k    = 16,
    parameter int NREG = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [REGW-1:0] waddr,
    input  logic [k-1:0]    wdata,
    input  logic [REGW-1:0] raddr,
    output logic [k-1:0]    rdata,
    input  logic [REGW-1:0] dbg_sel,
    output logic [k-1:0]    dbg_data
);
    logic [NREG-1:0][k-1:0] mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem <= '0;
        else if (we)
            mem[waddr] <= wdata;
    end

    assign rdata    = mem[raddr];
    assign dbg_data = mem[dbg_sel];
endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer: fetch two operands, run an external ALU, write back; or load an immediate.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int k    = 16,
    parameter int NREG = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_imm,
    input  logic [1:0]      cmd_op,
    input  logic [REGW-1:0] cmd_rd,
    input  logic [REGW-1:0] cmd_rn,
    input  logic [REGW-1:0] cmd_rm,
    input  logic [k-1:0]    cmd_data,
    output logic [k-1:0]    alu_ain,
    output logic [k-1:0]    alu_bin,
    output logic [1:0]      alu_op,
    input  logic [k-1:0]    alu_out,
    input  logic            alu_status,
    output logic            done,
    output logic            status_q,
    input  logic [REGW-1:0] dbg_sel,
    output logic [k-1:0]    dbg_data
);
    state_e          state, nxt;
    cmd_t            cmd_q;
    logic [k-1:0]    imm_q, a_q, b_q, c_q;
    logic            accept, rf_we;
    logic [REGW-1:0] rf_raddr;
    logic [k-1:0]    rf_rdata, rf_wdata;

    assign accept = cmd_valid & cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (accept) nxt = cmd_imm ? WRITE : LOADA;
            LOADA:   nxt = LOADB;
            LOADB:   nxt = EXEC;
            EXEC:    nxt = WRITE;
            WRITE:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        rf_we     = 1'b0;
        case (state)
            IDLE:    cmd_ready = 1'b1;
            WRITE:   rf_we     = 1'b1;
            default: ;
        endcase
    end

    // One read port serves both operand fetches; the state picks rn or rm.
    assign rf_raddr = (state == LOADB) ? cmd_q.rm : cmd_q.rn;
    assign rf_wdata = cmd_q.imm ? imm_q : c_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q    <= '0;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (accept) begin
                cmd_q <= '{imm: cmd_imm, op: cmd_op, rd: cmd_rd, rn: cmd_rn, rm: cmd_rm};
                imm_q <= cmd_data;
            end
            if (state == LOADA) a_q <= rf_rdata;
            if (state == LOADB) b_q <= rf_rdata;
            if (state == EXEC) begin
                c_q      <= alu_out;
                status_q <= alu_status;
            end
            // Registered so the pulse lines up with the register-file update.
            done <= rf_we;
        end
    end

    assign alu_ain = a_q;
    assign alu_bin = b_q;
    assign alu_op  = cmd_q.op;

    regfile #(.k(k), .NREG(NREG)) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (rf_we),
        .waddr    (cmd_q.rd),
        .wdata    (rf_wdata),
        .raddr    (rf_raddr),
        .rdata    (rf_rdata),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter k, default 16: datapath word width, matching the ALU operand width.
REQ-002 Parameter NREG, default 8: register-file depth; register index width is 3.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  command present.
REQ-006 cmd_ready  out  1  sequencer can accept a command.
REQ-007 cmd_imm  in  1  1 = immediate load (Rd <= cmd_data), 0 = ALU operation.
REQ-008 cmd_op  in  2  ALU op: 00 add, 01 sub, 10 and, 11 pass A.
REQ-009 cmd_rd, cmd_rn, cmd_rm  in  3 each  destination, operand-A and operand-B register indices.
REQ-010 cmd_data  in  k  immediate value, used only when cmd_imm=1.
REQ-011 alu_ain, alu_bin  out  k  operands driven to the external ALU.
REQ-012 alu_op  out  2  op code driven to the external ALU.
REQ-013 alu_out  in  k  combinational ALU result.
REQ-014 alu_status  in  1  ALU zero flag (1 when alu_out is all zeros).
REQ-015 done  out  1  one-cycle pulse when the destination register is written.
REQ-016 status_q  out  1  registered zero flag from the most recent ALU operation.
REQ-017 dbg_sel  in  3  debug read index; dbg_data  out  k  combinational read of register dbg_sel.

Function
REQ-018 FSM states: IDLE, LOADA, LOADB, EXEC, WRITE.
REQ-019 cmd_ready = 1 only in IDLE; a command is accepted on a clock edge with cmd_valid & cmd_ready.
REQ-020 On acceptance, latch cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_data; go to LOADA (cmd_imm=0) or WRITE (cmd_imm=1).
REQ-021 LOADA: A <= R[rn]; go to LOADB.
REQ-022 LOADB: B <= R[rm]; go to EXEC.
REQ-023 alu_ain = A, alu_bin = B, alu_op = latched op, in every state.
REQ-024 EXEC: C <= alu_out, status_q <= alu_status; go to WRITE.
REQ-025 WRITE: R[rd] <= C (ALU command) or the latched immediate (immediate command); done = 1; go to IDLE.
REQ-026 Latency from acceptance edge to done: 4 cycles for ALU commands, 1 cycle for immediate commands; next command may be accepted the cycle after done.
REQ-027 Arithmetic is modulo 2^k; carry/borrow is discarded; no overflow flag.
REQ-028 rn = rm is legal; rd equal to rn or rm is legal; the write uses C captured in EXEC.
REQ-029 status_q changes only in EXEC; immediate loads leave it unchanged.
REQ-030 cmd_* inputs are ignored outside IDLE; cmd_valid held high during a busy command does not abort it.

Reset
REQ-031 rst_n low forces state IDLE, A = B = C = 0, all registers 0, status_q = 0, done = 0, cmd_ready = 1 (after deassertion), asynchronously, including mid-command; the in-flight command is discarded and no write occurs.

Structure
REQ-032 A shared package holds the op-code constants (ADD, SUB, AND, MOVA) and the FSM state encoding.
REQ-033 The register file is a sub-module, regfile (NREG x k, one synchronous write port, two combinational read ports: operand read and debug read).
REQ-034 The ALU is not instantiated inside; the top level connects alu_* ports to an ALU instance.

Verification
REQ-035 Immediate 5 -> R1, immediate 3 -> R2, then add R3 = R1 + R2 -> dbg R3 = 0x0008, status_q = 0, done 4 cycles after acceptance.
REQ-036 sub R4 = R1 - R1 with R1 = 5 -> R4 = 0x0000, status_q = 1; then immediate load to R5 -> status_q remains 1.
REQ-037 sub R6 = R2 - R1 (3 - 5) -> R6 = 0xFFFE; add 0xFFFF + 0x0001 -> 0x0000, status_q = 1 (wraparound).
REQ-038 and R7 = 0xF0F0 & 0x0FF0 -> 0x00F0; pass-A with rd = rn = R7 -> R7 unchanged, done pulses once.
REQ-039 cmd_valid held high continuously with changing cmd_* while busy -> only IDLE-cycle commands execute; cmd_ready low in LOADA through WRITE.
REQ-040 rst_n asserted in EXEC of add to R3 -> R3 = 0, all registers 0, status_q = 0, no done pulse, cmd_ready = 1 on the first cycle after deassertion.
